// File: rtl/mem_load_unit.sv
// Memory stage: registers ALU writeback, or runs a valid/ready data-memory read
// for loads, extracts and extends the addressed byte/half/word, and writes back.
module mem_load_unit #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  rd_l3,
  input  logic [31:0] alu_q_l3,
  input  logic        load_l3,
  input  logic [2:0]  funct3_l3,
  output logic        stall_mem,
  output logic        dmem_req_valid,
  input  logic        dmem_req_ready,
  output logic [31:0] dmem_addr,
  input  logic        dmem_rsp_valid,
  input  logic [31:0] dmem_rsp_data,
  output logic        we_wb,
  output logic [4:0]  rd_wb,
  output logic [31:0] wdata_wb,
  output logic        misalign_wb,
  output logic        buserr_wb
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;

  state_t       state, state_next;
  logic [CW-1:0] cnt, cnt_next;
  logic [31:0]  addr_q, addr_next;
  logic [4:0]   rd_q, rd_next;
  logic [2:0]   f3_q, f3_next;
  logic         we_next, mis_next, bus_next, req_valid_next;
  logic [4:0]   rd_wb_next;
  logic [31:0]  wdata_next, dmem_addr_next;
  logic         misaligned;
  logic [7:0]   byte_sel;
  logic [15:0]  half_sel;
  logic [31:0]  load_data;

  // Halfwords need addr[0]=0; words (and unlisted funct3, treated as lw) need addr[1:0]=0.
  always_comb begin
    case (funct3_l3)
      3'b000, 3'b100: misaligned = 1'b0;
      3'b001, 3'b101: misaligned = alu_q_l3[0];
      default:        misaligned = (alu_q_l3[1:0] != 2'b00);
    endcase
  end

  always_comb begin
    case (addr_q[1:0])
      2'd0:    byte_sel = dmem_rsp_data[7:0];
      2'd1:    byte_sel = dmem_rsp_data[15:8];
      2'd2:    byte_sel = dmem_rsp_data[23:16];
      default: byte_sel = dmem_rsp_data[31:24];
    endcase
    half_sel = addr_q[1] ? dmem_rsp_data[31:16] : dmem_rsp_data[15:0];
    case (f3_q)
      3'b000:  load_data = {{24{byte_sel[7]}}, byte_sel};
      3'b100:  load_data = {24'd0, byte_sel};
      3'b001:  load_data = {{16{half_sel[15]}}, half_sel};
      3'b101:  load_data = {16'd0, half_sel};
      default: load_data = dmem_rsp_data;
    endcase
  end

  always_comb begin
    state_next     = state;
    cnt_next       = cnt;
    addr_next      = addr_q;
    rd_next        = rd_q;
    f3_next        = f3_q;
    we_next        = 1'b0;
    rd_wb_next     = rd_wb;
    wdata_next     = wdata_wb;
    mis_next       = 1'b0;
    bus_next       = 1'b0;
    req_valid_next = dmem_req_valid;
    dmem_addr_next = dmem_addr;
    stall_mem      = 1'b0;
    case (state)
      IDLE: begin
        if (!load_l3) begin
          we_next = (rd_l3 != 5'd0);
          if (rd_l3 != 5'd0) begin
            rd_wb_next = rd_l3;
            wdata_next = alu_q_l3;
          end
        end else if (misaligned) begin
          mis_next = 1'b1;
        end else begin
          stall_mem      = 1'b1;
          addr_next      = alu_q_l3;
          rd_next        = rd_l3;
          f3_next        = funct3_l3;
          req_valid_next = 1'b1;
          dmem_addr_next = {alu_q_l3[31:2], 2'b00};
          state_next     = REQ;
        end
      end
      REQ: begin
        stall_mem = 1'b1;
        if (dmem_req_ready) begin
          req_valid_next = 1'b0;
          cnt_next       = '0;
          state_next     = WAIT;
        end
      end
      WAIT: begin
        // A response on the timeout cycle still wins over the abort.
        if (dmem_rsp_valid) begin
          we_next = (rd_q != 5'd0);
          if (rd_q != 5'd0) begin
            rd_wb_next = rd_q;
            wdata_next = load_data;
          end
          state_next = IDLE;
        end else begin
          stall_mem = 1'b1;
          if (cnt == CW'(TIMEOUT_CYCLES)) begin
            bus_next   = 1'b1;
            cnt_next   = '0;
            state_next = IDLE;
          end else begin
            cnt_next = cnt + 1'b1;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= IDLE;
      cnt            <= '0;
      addr_q         <= '0;
      rd_q           <= '0;
      f3_q           <= '0;
      we_wb          <= 1'b0;
      rd_wb          <= '0;
      wdata_wb       <= '0;
      misalign_wb    <= 1'b0;
      buserr_wb      <= 1'b0;
      dmem_req_valid <= 1'b0;
      dmem_addr      <= '0;
    end else begin
      state          <= state_next;
      cnt            <= cnt_next;
      addr_q         <= addr_next;
      rd_q           <= rd_next;
      f3_q           <= f3_next;
      we_wb          <= we_next;
      rd_wb          <= rd_wb_next;
      wdata_wb       <= wdata_next;
      misalign_wb    <= mis_next;
      buserr_wb      <= bus_next;
      dmem_req_valid <= req_valid_next;
      dmem_addr      <= dmem_addr_next;
    end
  end

endmodule
